// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, W iterations, start/busy/done handshake.
// Define DIV_SEQ_ROUND_EN to round the quotient to nearest (half up, saturating).
module div_seq #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_zero
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rmd_q, rmd_d;
  logic          dz_q, dz_d;
  logic          done_q, done_d;

  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic          q_bit;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  quo_next;
  logic [W-1:0]  quo_final;
  logic          last;

  // Partial remainder stays below the divisor, so the trial's MSB is a clean borrow flag.
  always_comb begin
    shifted  = {rem_q, dvd_q[W-1]};
    trial    = shifted - {1'b0, dvs_q};
    q_bit    = ~trial[W];
    rem_next = q_bit ? trial[W-1:0] : shifted[W-1:0];
    quo_next = {dvd_q[W-2:0], q_bit};
    last     = (cnt_q == CW'(W - 1));
  end

`ifdef DIV_SEQ_ROUND_EN
  logic round_up;
  always_comb begin
    round_up  = ({rem_next, 1'b0} >= {1'b0, dvs_q}) && (quo_next != '1);
    quo_final = quo_next + W'(round_up);
  end
`else
  always_comb begin
    quo_final = quo_next;
  end
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d  = '1;
            rmd_d  = dividend;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // The dividend shift register fills with quotient bits from the LSB end.
        dvd_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          quo_d   = quo_final;
          rmd_d   = rem_next;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (W=32): latency, handshake, divide-by-zero, reset abort, rounding.
module tb_div_seq;

  localparam int unsigned W = 32;
`ifdef DIV_SEQ_ROUND_EN
  localparam bit Rnd = 1'b1;
`else
  localparam bit Rnd = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_seq #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat counts edges after the accepting edge until done is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  int lat, bc, ndone, t;
  logic [W-1:0] qs, rs;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) tick();
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_quo", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dz", W'(div_zero), 0);
    rst = 1'b0;
    tick();

    run_op(32'd100, 32'd7, lat, bc);
    check("100/7_lat", W'(lat), 32);
    check("100/7_busy", W'(bc), 32);
    check("100/7_quo", quotient, 14);
    check("100/7_rem", remainder, 2);
    check("100/7_dz", W'(div_zero), 0);
    tick();
    check("done_pulse", W'(done), 0);
    check("quo_held", quotient, 14);

    run_op(32'd100, 32'd8, lat, bc);
    check("100/8_quo", quotient, Rnd ? 32'd13 : 32'd12);
    check("100/8_rem", remainder, 4);

    run_op(32'hFFFF_FFFF, 32'd2, lat, bc);
    check("max/2_quo", quotient, Rnd ? 32'h8000_0000 : 32'h7FFF_FFFF);
    check("max/2_rem", remainder, 1);

    run_op(32'd5, 32'd0, lat, bc);
    check("5/0_lat", W'(lat), 0);
    check("5/0_busy", W'(bc), 0);
    check("5/0_quo", quotient, 32'hFFFF_FFFF);
    check("5/0_rem", remainder, 5);
    check("5/0_dz", W'(div_zero), 1);
    tick();
    check("5/0_done_pulse", W'(done), 0);

    run_op(32'd9, 32'd3, lat, bc);
    check("9/3_lat", W'(lat), 32);
    check("9/3_quo", quotient, 3);
    check("9/3_rem", remainder, 0);
    check("9/3_dz", W'(div_zero), 0);

    // Start while busy and operand changes mid-run must be ignored.
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (9) tick();
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 32'd7;
    divisor  = 32'd3;
    ndone    = 0;
    qs       = '0;
    rs       = '1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        ndone++;
        qs = quotient;
        rs = remainder;
      end
      tick();
    end
    check("busy_start_ndone", W'(ndone), 1);
    check("busy_start_quo", qs, 100);
    check("busy_start_rem", rs, 0);

    // Start held high: results every W+1 cycles.
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    t = 0;
    while (!done && t < 100) begin
      tick();
      t++;
    end
    t = 0;
    do begin
      tick();
      t++;
    end while (!done && t < 100);
    start = 1'b0;
    check("held_interval", W'(t), 33);
    check("held_quo", quotient, 100);
    tick();
    check("held_stop_busy", W'(busy), 0);

    // Reset mid-run aborts with no done.
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (14) tick();
    check("pre_rst_busy", W'(busy), 1);
    rst = 1'b1;
    #1;
    check("midrst_quo", quotient, 0);
    check("midrst_busy", W'(busy), 0);
    check("midrst_done", W'(done), 0);
    check("midrst_dz", W'(div_zero), 0);
    repeat (3) tick();
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("post_rst_quiet", W'(ndone), 0);

    run_op(32'd0, 32'd3, lat, bc);
    check("0/3_lat", W'(lat), 32);
    check("0/3_quo", quotient, 0);
    check("0/3_rem", remainder, 0);

    run_op(32'd3, 32'hFFFF_FFFF, lat, bc);
    check("3/max_quo", quotient, 0);
    check("3/max_rem", remainder, 3);

    run_op(32'hFFFF_FFFF, 32'd1, lat, bc);
    check("max/1_quo", quotient, 32'hFFFF_FFFF);
    check("max/1_rem", remainder, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
